// File: rtl/decode_stage_if.sv
// Handshake, writeback and decoded-bundle signals of the decode stage.
// The slave modport is the decode stage itself; master is the surrounding pipeline.
interface decode_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_alu_op;
   logic [31:0] out_rs_val;
   logic [31:0] out_rt_val;
   logic [15:0] out_imm16;
   logic [25:0] out_target;
   logic [4:0]  out_dst;
   logic        out_we;
   logic        out_illegal;
   logic [31:0] out_pc;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready, wb_en, wb_addr, wb_data,
      output in_ready, out_valid, out_alu_op, out_rs_val, out_rt_val, out_imm16,
             out_target, out_dst, out_we, out_illegal, out_pc
   );

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready, wb_en, wb_addr, wb_data,
      input  in_ready, out_valid, out_alu_op, out_rs_val, out_rt_val, out_imm16,
             out_target, out_dst, out_we, out_illegal, out_pc
   );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: field split, alu_op mapping, 32x32 register file
// with writeback bypass, and a single valid/ready output register.
module decode_stage #(
   parameter logic [5:0] ILLEGAL_OP = 6'h3F,
   parameter bit         BYPASS_EN  = 1'b1
) (
   input logic           clk,
   input logic           rst,
   decode_stage_if.slave bus
);
   logic [5:0]  op_s;
   logic [4:0]  rs_s;
   logic [4:0]  rt_s;
   logic [4:0]  rd_s;
   logic [5:0]  funct_s;
   logic [5:0]  alu_op_s;
   logic [4:0]  dst_s;
   logic        we_s;
   logic        illegal_s;
   logic [31:0] rs_val_s;
   logic [31:0] rt_val_s;
   logic        accept_s;

   logic [31:0] regs_r [32];
   logic        valid_r;
   logic [5:0]  alu_op_r;
   logic [31:0] rs_val_r;
   logic [31:0] rt_val_r;
   logic [15:0] imm16_r;
   logic [25:0] target_r;
   logic [4:0]  dst_r;
   logic        we_r;
   logic        illegal_r;
   logic [31:0] pc_r;

   assign op_s    = bus.in_instr[31:26];
   assign rs_s    = bus.in_instr[25:21];
   assign rt_s    = bus.in_instr[20:16];
   assign rd_s    = bus.in_instr[15:11];
   assign funct_s = bus.in_instr[5:0];

   assign accept_s = bus.in_valid & bus.in_ready;

   // Opcode/funct to alu_op, destination and write-enable mapping.
   always_comb begin
      alu_op_s  = ILLEGAL_OP;
      dst_s     = 5'd0;
      we_s      = 1'b0;
      illegal_s = 1'b1;
      if (bus.in_instr == 32'h0000_0000) begin
         alu_op_s  = 6'h00;
         illegal_s = 1'b0;
      end else if (op_s == 6'h00) begin
         case (funct_s)
            6'h20:   begin alu_op_s = 6'h00; dst_s = rd_s; we_s = 1'b1; illegal_s = 1'b0; end
            6'h22:   begin alu_op_s = 6'h01; dst_s = rd_s; we_s = 1'b1; illegal_s = 1'b0; end
            6'h24:   begin alu_op_s = 6'h02; dst_s = rd_s; we_s = 1'b1; illegal_s = 1'b0; end
            6'h25:   begin alu_op_s = 6'h03; dst_s = rd_s; we_s = 1'b1; illegal_s = 1'b0; end
            6'h26:   begin alu_op_s = 6'h04; dst_s = rd_s; we_s = 1'b1; illegal_s = 1'b0; end
            default: begin alu_op_s = ILLEGAL_OP; dst_s = 5'd0; we_s = 1'b0; illegal_s = 1'b1; end
         endcase
      end else if (op_s == 6'h08) begin
         alu_op_s  = 6'h10;
         dst_s     = rt_s;
         we_s      = 1'b1;
         illegal_s = 1'b0;
      end else begin
         alu_op_s  = ILLEGAL_OP;
         illegal_s = 1'b1;
      end
   end

   // Operand read; a writeback landing this cycle is forwarded when bypass is enabled.
   always_comb begin
      rs_val_s = 32'd0;
      rt_val_s = 32'd0;
      if (rs_s == 5'd0) begin
         rs_val_s = 32'd0;
      end else if (BYPASS_EN && bus.wb_en && (bus.wb_addr == rs_s)) begin
         rs_val_s = bus.wb_data;
      end else begin
         rs_val_s = regs_r[rs_s];
      end
      if (rt_s == 5'd0) begin
         rt_val_s = 32'd0;
      end else if (BYPASS_EN && bus.wb_en && (bus.wb_addr == rt_s)) begin
         rt_val_s = bus.wb_data;
      end else begin
         rt_val_s = regs_r[rt_s];
      end
   end

   // Output bundle register, valid tracking and register file writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r   <= 1'b0;
         alu_op_r  <= 6'd0;
         rs_val_r  <= 32'd0;
         rt_val_r  <= 32'd0;
         imm16_r   <= 16'd0;
         target_r  <= 26'd0;
         dst_r     <= 5'd0;
         we_r      <= 1'b0;
         illegal_r <= 1'b0;
         pc_r      <= 32'd0;
         for (int i = 0; i < 32; i++) regs_r[i] <= 32'd0;
      end else begin
         if (bus.wb_en && (bus.wb_addr != 5'd0)) regs_r[bus.wb_addr] <= bus.wb_data;

         if (bus.flush)          valid_r <= 1'b0;
         else if (accept_s)      valid_r <= 1'b1;
         else if (bus.out_ready) valid_r <= 1'b0;

         // A flush in the accept cycle drops the incoming instruction entirely.
         if (accept_s && !bus.flush) begin
            alu_op_r  <= alu_op_s;
            rs_val_r  <= rs_val_s;
            rt_val_r  <= rt_val_s;
            imm16_r   <= bus.in_instr[15:0];
            target_r  <= bus.in_instr[25:0];
            dst_r     <= dst_s;
            we_r      <= we_s & (dst_s != 5'd0);
            illegal_r <= illegal_s;
            pc_r      <= bus.in_pc;
         end
      end
   end

   assign bus.in_ready    = ~valid_r | bus.out_ready;
   assign bus.out_valid   = valid_r;
   assign bus.out_alu_op  = alu_op_r;
   assign bus.out_rs_val  = rs_val_r;
   assign bus.out_rt_val  = rt_val_r;
   assign bus.out_imm16   = imm16_r;
   assign bus.out_target  = target_r;
   assign bus.out_dst     = dst_r;
   assign bus.out_we      = we_r;
   assign bus.out_illegal = illegal_r;
   assign bus.out_pc      = pc_r;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a bypassing and a non-bypassing instance
// see identical stimulus; a reference model predicts each bundle.
module tb_decode_stage;
   typedef struct packed {
      logic [5:0]  alu_op;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [15:0] imm16;
      logic [25:0] target;
      logic [4:0]  dst;
      logic        we;
      logic        illegal;
      logic [31:0] pc;
   } bundle_t;

   localparam logic [5:0] RFUNCT [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_ready;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   always #5 clk = ~clk;

   decode_stage_if ifa ();
   decode_stage_if ifb ();

   assign ifa.in_valid  = in_valid;
   assign ifa.in_instr  = in_instr;
   assign ifa.in_pc     = in_pc;
   assign ifa.flush     = flush;
   assign ifa.out_ready = out_ready;
   assign ifa.wb_en     = wb_en;
   assign ifa.wb_addr   = wb_addr;
   assign ifa.wb_data   = wb_data;
   assign ifb.in_valid  = in_valid;
   assign ifb.in_instr  = in_instr;
   assign ifb.in_pc     = in_pc;
   assign ifb.flush     = flush;
   assign ifb.out_ready = out_ready;
   assign ifb.wb_en     = wb_en;
   assign ifb.wb_addr   = wb_addr;
   assign ifb.wb_data   = wb_data;

   decode_stage #(.ILLEGAL_OP(6'h3F), .BYPASS_EN(1'b1)) dut_byp (
      .clk (clk), .rst (rst), .bus (ifa)
   );
   decode_stage #(.ILLEGAL_OP(6'h3F), .BYPASS_EN(1'b0)) dut_nobyp (
      .clk (clk), .rst (rst), .bus (ifb)
   );

   bundle_t act0;
   bundle_t act1;
   assign act0 = {ifa.out_alu_op, ifa.out_rs_val, ifa.out_rt_val, ifa.out_imm16,
                  ifa.out_target, ifa.out_dst, ifa.out_we, ifa.out_illegal, ifa.out_pc};
   assign act1 = {ifb.out_alu_op, ifb.out_rs_val, ifb.out_rt_val, ifb.out_imm16,
                  ifb.out_target, ifb.out_dst, ifb.out_we, ifb.out_illegal, ifb.out_pc};

   int          errors = 0;
   int          checks = 0;
   bit          mon_en = 1'b0;
   bit          m_valid = 1'b0;
   logic [31:0] mregs [32];
   bundle_t     expq0 [$];
   bundle_t     expq1 [$];

   task automatic check_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_bun(input string name, input bundle_t got, input bundle_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rd_reg(input logic [4:0] idx, input bit byp);
      if (idx == 5'd0) return 32'd0;
      if (byp && wb_en && wb_addr == idx) return wb_data;
      return mregs[idx];
   endfunction

   // Reference decode straight from the instruction-set table.
   function automatic bundle_t model(input logic [31:0] instr, input logic [31:0] pc, input bit byp);
      bundle_t b;
      b         = '0;
      b.pc      = pc;
      b.imm16   = instr[15:0];
      b.target  = instr[25:0];
      b.rs_val  = rd_reg(instr[25:21], byp);
      b.rt_val  = rd_reg(instr[20:16], byp);
      b.alu_op  = 6'h3F;
      b.illegal = 1'b1;
      if (instr == 32'd0) begin
         b.alu_op  = 6'h00;
         b.illegal = 1'b0;
      end else if (instr[31:26] == 6'h08) begin
         b.alu_op  = 6'h10;
         b.illegal = 1'b0;
         b.dst     = instr[20:16];
      end else if (instr[31:26] == 6'h00) begin
         for (int i = 0; i < 5; i++) begin
            if (instr[5:0] == RFUNCT[i]) begin
               b.alu_op  = 6'(i);
               b.illegal = 1'b0;
               b.dst     = instr[15:11];
            end
         end
      end
      b.we = !b.illegal && (b.dst != 5'd0);
      return b;
   endfunction

   // One cycle of stimulus; the model advances at the clock edge.
   task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc, input bit fl,
                       input bit ordy, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit r);
      bit      acc;
      bundle_t e0;
      bundle_t e1;
      rst = r; in_valid = v; in_instr = ins; in_pc = pc; flush = fl;
      out_ready = ordy; wb_en = we; wb_addr = wa; wb_data = wd;
      #2;
      if (mon_en) begin
         check_bit("in_ready_byp", ifa.in_ready, !m_valid || ordy);
         check_bit("in_ready_nobyp", ifb.in_ready, !m_valid || ordy);
      end
      acc = v && (!m_valid || ordy);
      e0  = model(ins, pc, 1'b1);
      e1  = model(ins, pc, 1'b0);
      @(posedge clk);
      #1;
      if (r || fl) begin
         if (m_valid && !ordy) begin
            if (expq0.size() > 0) void'(expq0.pop_back());
            if (expq1.size() > 0) void'(expq1.pop_back());
         end
         m_valid = 1'b0;
      end else if (acc) begin
         expq0.push_back(e0);
         expq1.push_back(e1);
         m_valid = 1'b1;
      end else if (ordy) begin
         m_valid = 1'b0;
      end
      if (r) begin
         for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      end else if (we && wa != 5'd0) begin
         mregs[wa] = wd;
      end
   endtask

   // Monitor: compare presented bundles against the scoreboard, pop on consume.
   always @(negedge clk) begin
      if (mon_en) begin
         check_bit("out_valid_byp", ifa.out_valid, m_valid);
         check_bit("out_valid_nobyp", ifb.out_valid, m_valid);
         if (ifa.out_valid) begin
            if (expq0.size() == 0) begin
               checks++; errors++;
               $display("FAIL bundle_byp: got unexpected %h expected none at %0t", act0, $time);
            end else begin
               check_bun("bundle_byp", act0, expq0[0]);
               if (out_ready) void'(expq0.pop_front());
            end
         end
         if (ifb.out_valid) begin
            if (expq1.size() == 0) begin
               checks++; errors++;
               $display("FAIL bundle_nobyp: got unexpected %h expected none at %0t", act1, $time);
            end else begin
               check_bun("bundle_nobyp", act1, expq1[0]);
               if (out_ready) void'(expq1.pop_front());
            end
         end
      end
   end

   initial begin
      logic [31:0] ins;
      logic [31:0] pc;
      rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; flush = 1'b0;
      out_ready = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      @(posedge clk);
      #1;
      step(1'b1, 32'h00A63820, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h77, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      check_bit("reset_valid", ifa.out_valid, 1'b0);
      check_bun("reset_bundle_byp", act0, '0);
      check_bun("reset_bundle_nobyp", act1, '0);
      mon_en = 1'b1;

      // Writebacks then ADD r7,r5,r6 and ADDI r3,r5,-1.
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h1234, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h10, 1'b0);
      step(1'b1, 32'h00A63820, 32'h100, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      step(1'b1, 32'h20A3FFFF, 32'h104, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      // Same-cycle writeback of r5 while reading it.
      step(1'b1, 32'h00A63820, 32'h108, 1'b0, 1'b1, 1'b1, 5'd5, 32'hCAFE, 1'b0);
      // Stall three cycles, then release.
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'h00A63022, 32'h10C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      step(1'b1, 32'h00A63022, 32'h10C, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      step(1'b1, 32'hFC000000, 32'h110, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      step(1'b1, 32'h00000000, 32'h114, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      // Flush with accept and a bundle present, then flush of a stalled bundle.
      step(1'b1, 32'h00A63824, 32'h118, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      step(1'b1, 32'h20A3FFFF, 32'h11C, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      step(1'b1, 32'h00A63825, 32'h120, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      // Writes to r0 are ignored, including the bypass path.
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h5, 1'b0);
      step(1'b1, 32'h00003820, 32'h124, 1'b0, 1'b1, 1'b1, 5'd0, 32'h5, 1'b0);
      // Reset mid-stream with a stalled bundle.
      step(1'b1, 32'h00A63826, 32'h128, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      step(1'b1, 32'h00A63820, 32'h12C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      step(1'b1, 32'h00A63820, 32'h130, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);

      pc = 32'h1000;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 4))
            0:       ins = {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, RFUNCT[$urandom_range(0, 4)]};
            1:       ins = {6'h08, 26'($urandom)};
            2:       ins = $urandom;
            3:       ins = 32'd0;
            default: ins = {6'h00, 20'($urandom), 6'($urandom)};
         endcase
         step($urandom_range(0, 9) < 7, ins, pc, $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
              $urandom, $urandom_range(0, 99) == 0);
         pc = pc + 32'd4;
      end

      for (int i = 0; i < 3; i++)
         step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      checks++;
      if (expq0.size() != 0 || expq1.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d pending expected 0/0", expq0.size(), expq1.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
